xs3_serial_subtractor: RTL and testbench
========================================

Name: xs3_serial_subtractor

Overview:
Digit-serial multi-digit excess-3 (XS-3) subtractor; the subtract-direction counterpart of the team's XS-3 adder.
Computes A − B on NDIG packed XS-3 digits, one digit per clock, LSB digit first.
If the result is negative, a second serial pass re-complements it to sign-magnitude form.
Sits behind a simple start/done handshake, for use by BCD/XS-3 arithmetic controllers.

Parameters:
NDIG, 4, number of XS-3 digits per operand (≥1); the operand width is 4*NDIG.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
a  in  4*NDIG  minuend, packed XS-3, digit 0 in [3:0]
b  in  4*NDIG  subtrahend, packed XS-3
busy  out  1  high while an operation is in progress
done  out  1  one-cycle result-valid pulse
diff  out  4*NDIG  XS-3 magnitude of A−B
neg  out  1  result negative (A<B)
err  out  1  at least one input digit outside 0011..1100

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset: state=IDLE; busy, done, diff, neg and err are all 0. The digit index and borrow are cleared. Reset mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, SUB, RECOMP, DONE.
- IDLE:
  - On an edge with start=1, capture a and b into internal registers.
  - Clear diff, neg, err, the index (idx=0) and the borrow (bor=0). Go to SUB.
  - busy is 1 from that edge.
- SUB: each edge processes digit idx.
  - d = a[idx] − b[idx] − bor, computed as 4-bit binary with borrow-out bo.
  - Result digit = d+3 if bo=0, else d−3 (both mod 16).
  - Write the result digit to diff[idx], set bor=bo, idx++.
  - err |= (a[idx] or b[idx] outside 3..12).
  - After digit NDIG−1:
    - If final bor=1 and err=0: idx=0, bor=0, go to RECOMP.
    - Otherwise go to DONE.
- RECOMP: each edge computes 0011 − diff[idx] − bor with the same digit rule, writes the result back to diff[idx], and sets neg=1.
  - After digit NDIG−1, go to DONE.
  - The final borrow of this pass is discarded.
- DONE: one cycle. done=1 and busy=0; next state is IDLE.
- Output hold: diff, neg and err hold their values until the next accepted start.
- Latency from the start-sampling edge: done is high in the cycle after edge NDIG+1. With recomplement, it is high in the cycle after edge 2·NDIG+1.
- start while busy or in DONE: ignored, not queued.
- Input stability: a and b may change after capture without effect.
- err=1: the subtraction still completes, RECOMP is skipped, neg=0, and diff is undefined-but-deterministic (the raw pass-1 value).
- Zero result: A=B gives diff = all digits 0011, neg=0 (no negative zero).

Decomposition:
- Shared package xs3_pkg:
  - XS3_ZERO=4'b0011, XS3_MIN=4'd3, XS3_MAX=4'd12.
  - Function xs3_valid(digit).
  - State enumeration encoding for this FSM.
- Sub-module xs3_digit_sub: combinational.
  - Inputs x, y (4 bits) and bin.
  - Outputs z (4 bits) and bout.
  - Implements the ±3 correction.
  - Shared by SUB and RECOMP through an operand mux.

Test Plan:
- NDIG=4, A=5729 (a=16'h8A5C), B=1234 (b=16'h4567), start pulse -> done in the cycle after edge 5, diff=16'h77C8 (4495), neg=0, err=0, busy high for cycles 1–4.
- A=1234, B=5729 -> done in the cycle after edge 9, diff=16'h77C8, neg=1.
- A=0000 (16'h3333), B=0001 (16'h3334) -> diff=16'h3334, neg=1. A=B=16'h3333 -> diff=16'h3333, neg=0.
- a=16'h8A5F (invalid digit 0xF) -> err=1, neg=0, done after 5 edges with no RECOMP.
- start held high throughout a negative operation -> exactly one done. The next operation begins only on the edge after done, with new operands captured there.
- rst asserted in the RECOMP cycle 2 -> next cycle IDLE, all outputs 0, no done. A following start completes normally.

Source files
------------

// File: rtl/xs3_pkg.sv
// Shared excess-3 constants, digit validity check and the serial subtractor state encoding.
package xs3_pkg;

    localparam logic [3:0] XS3_ZERO = 4'b0011;
    localparam logic [3:0] XS3_MIN  = 4'd3;
    localparam logic [3:0] XS3_MAX  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SUB    = 2'd1,
        ST_RECOMP = 2'd2,
        ST_DONE   = 2'd3
    } xs3_sub_state_e;

    function automatic logic xs3_valid(input logic [3:0] digit);
        return (digit >= XS3_MIN) && (digit <= XS3_MAX);
    endfunction

endpackage

// File: rtl/xs3_digit_sub.sv
// One XS-3 digit of x - y - bin: binary subtract, then +3 without borrow or -3 with borrow.
module xs3_digit_sub (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] z,
    output logic       bout
);

    logic [4:0] raw_c;

    always_comb begin
        raw_c = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
        bout  = raw_c[4];
        z     = raw_c[4] ? (raw_c[3:0] - 4'd3) : (raw_c[3:0] + 4'd3);
    end

endmodule

// File: rtl/xs3_serial_subtractor.sv
// Digit-serial XS-3 subtractor: one digit per clock, LSB first, with an optional
// second pass that turns a negative raw difference into sign-magnitude form.
module xs3_serial_subtractor
    import xs3_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*NDIG-1:0]   a,
    input  logic [4*NDIG-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   diff,
    output logic                neg,
    output logic                err
);

    localparam int unsigned W    = 4 * NDIG;
    localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    xs3_sub_state_e  state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    diff_q;
    logic [IDXW-1:0] idx_q;
    logic            bor_q;
    logic            busy_q;
    logic            done_q;
    logic            neg_q;
    logic            err_q;

    logic [3:0] a_dig_c;
    logic [3:0] b_dig_c;
    logic [3:0] x_c;
    logic [3:0] y_c;
    logic [3:0] z_c;
    logic       bout_c;
    logic       dig_err_c;
    logic       err_acc_c;
    logic       last_c;

    // Operand mux: SUB uses the captured operands, RECOMP computes 0011 - diff.
    always_comb begin
        a_dig_c   = a_q[4*int'(idx_q) +: 4];
        b_dig_c   = b_q[4*int'(idx_q) +: 4];
        x_c       = a_dig_c;
        y_c       = b_dig_c;
        if (state_q == ST_RECOMP) begin
            x_c = XS3_ZERO;
            y_c = diff_q[4*int'(idx_q) +: 4];
        end
        dig_err_c = !xs3_valid(a_dig_c) || !xs3_valid(b_dig_c);
        err_acc_c = err_q | dig_err_c;
        last_c    = (idx_q == IDXW'(NDIG - 1));
    end

    xs3_digit_sub u_digit_sub (
        .x    (x_c),
        .y    (y_c),
        .bin  (bor_q),
        .z    (z_c),
        .bout (bout_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            bor_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        diff_q  <= '0;
                        neg_q   <= 1'b0;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        bor_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    diff_q[4*int'(idx_q) +: 4] <= z_c;
                    bor_q <= bout_c;
                    err_q <= err_acc_c;
                    if (last_c) begin
                        // A final borrow on clean inputs means A<B: re-complement the result.
                        if (bout_c && !err_acc_c) begin
                            idx_q   <= '0;
                            bor_q   <= 1'b0;
                            state_q <= ST_RECOMP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                ST_RECOMP: begin
                    diff_q[4*int'(idx_q) +: 4] <= z_c;
                    neg_q <= 1'b1;
                    if (last_c) begin
                        bor_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        bor_q <= bout_c;
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule

// File: tb/tb_xs3_serial_subtractor.sv
// Directed self-checking bench for the 4-digit XS-3 serial subtractor.
module tb_xs3_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        neg;
    logic        err;

    int checks;
    int failures;

    xs3_serial_subtractor #(.NDIG(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation: start is sampled on edge 0, then done must appear after edge elat.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] ed, input logic en, input logic ee, input int elat);
        int n;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hFFFF; b = 16'h0000;
        check_eq({tag, "_busy0"}, 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'(elat));
        check_eq({tag, "_diff"}, 32'(diff), 32'(ed));
        check_eq({tag, "_neg"}, 32'(neg), 32'(en));
        check_eq({tag, "_err"}, 32'(err), 32'(ee));
        check_eq({tag, "_busyd"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_hold"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        int n;
        int dones;
        int busy_cnt;
        checks   = 0;
        failures = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_flags", 32'({neg, err}), 32'd0);
        rst = 1'b0;

        run_op("pos", 16'h8A5C, 16'h4567, 16'h77C8, 1'b0, 1'b0, 5);
        run_op("negv", 16'h4567, 16'h8A5C, 16'h77C8, 1'b1, 1'b0, 9);
        run_op("zm1", 16'h3333, 16'h3334, 16'h3334, 1'b1, 1'b0, 9);
        run_op("eq", 16'h3333, 16'h3333, 16'h3333, 1'b0, 1'b0, 5);
        run_op("erra", 16'h8A5F, 16'h4567, 16'h77CB, 1'b0, 1'b1, 5);
        run_op("errb", 16'h4567, 16'h8A5F, 16'h8835, 1'b0, 1'b1, 5);

        // Busy profile of a positive op: high for exactly 4 sampled cycles.
        @(negedge clk);
        a = 16'h8A5C; b = 16'h4567; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
        end
        check_eq("busy_len", 32'(busy_cnt), 32'd4);

        // start held high: one done per operation, next capture on the edge after done.
        @(negedge clk);
        a = 16'h4567; b = 16'h8A5C; start = 1'b1;
        @(posedge clk); #1;
        dones = 0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("held_lat", 32'(n), 32'd9);
        check_eq("held_diff", 32'(diff), 32'h77C8);
        a = 16'h8A5C; b = 16'h4567;
        @(posedge clk); #1;
        check_eq("held_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check_eq("held_dones", 32'(dones), 32'd0);
        check_eq("held2_done", 32'(done), 32'd1);
        check_eq("held2_diff", 32'(diff), 32'h77C8);
        check_eq("held2_neg", 32'(neg), 32'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);

        // Reset during the second RECOMP cycle aborts with no done.
        @(negedge clk);
        a = 16'h4567; b = 16'h8A5C; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_diff", 32'(diff), 32'd0);
        check_eq("abort_flags", 32'({done, neg, err}), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check_eq("abort_nodone", 32'(dones), 32'd0);

        run_op("after", 16'h4567, 16'h8A5C, 16'h77C8, 1'b1, 1'b0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
